// File: rtl/iic_target_rx.sv
// Write-only I2C target receiver: oversampled SCL/SDA, START/STOP detection,
// 7-bit address match with ACK, parallel byte output with one-cycle strobe.
module iic_target_rx #(
  parameter logic [6:0] OWN_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_match,
  output logic       busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  state_t state, state_nxt;

  logic scl_s1, scl_s2, scl_prev;
  logic sda_s1, sda_s2, sda_prev;

  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [BYTE_W-1:0] shift, shift_nxt;
  logic [BYTE_W-1:0] rx_data_nxt;
  logic              rx_valid_nxt, sda_oe_nxt, addr_match_nxt, busy_nxt;

  logic scl_rise_c, scl_fall_c, start_c, stop_c, last_bit_c;

  // Two-flop synchronizers plus history flop; reset to the bus-idle level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_prev <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_s1   <= scl;
      scl_s2   <= scl_s1;
      scl_prev <= scl_s2;
      sda_s1   <= sda_in;
      sda_s2   <= sda_s1;
      sda_prev <= sda_s2;
    end
  end

  // Bus events derived from synchronized samples only.
  assign scl_rise_c = !scl_prev && scl_s2;
  assign scl_fall_c = scl_prev && !scl_s2;
  assign start_c    = scl_s2 && sda_prev && !sda_s2;
  assign stop_c     = scl_s2 && !sda_prev && sda_s2;
  assign last_bit_c = (bit_cnt == CNT_W'(BYTE_W));

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      sda_oe     <= 1'b0;
      addr_match <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift      <= shift_nxt;
      rx_data    <= rx_data_nxt;
      rx_valid   <= rx_valid_nxt;
      sda_oe     <= sda_oe_nxt;
      addr_match <= addr_match_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state and output logic; STOP/START override any state action.
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shift_nxt      = shift;
    rx_data_nxt    = rx_data;
    rx_valid_nxt   = 1'b0;
    sda_oe_nxt     = sda_oe;
    addr_match_nxt = addr_match;
    busy_nxt       = busy;

    if (stop_c) begin
      state_nxt      = IDLE;
      bit_cnt_nxt    = '0;
      sda_oe_nxt     = 1'b0;
      addr_match_nxt = 1'b0;
      busy_nxt       = 1'b0;
    end else if (start_c) begin
      state_nxt      = ADDR;
      bit_cnt_nxt    = '0;
      sda_oe_nxt     = 1'b0;
      addr_match_nxt = 1'b0;
      busy_nxt       = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          sda_oe_nxt = 1'b0;
        end
        ADDR, DATA: begin
          if (scl_rise_c && !last_bit_c) begin
            shift_nxt   = {shift[BYTE_W-2:0], sda_s2};
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end else if (scl_fall_c && last_bit_c) begin
            bit_cnt_nxt = '0;
            if (state == DATA) begin
              rx_data_nxt  = shift;
              rx_valid_nxt = 1'b1;
              sda_oe_nxt   = 1'b1;
              state_nxt    = DATA_ACK;
            end else if (shift[7:1] == OWN_ADDR && !shift[0]) begin
              sda_oe_nxt     = 1'b1;
              addr_match_nxt = 1'b1;
              state_nxt      = ADDR_ACK;
            end else begin
              state_nxt = IGNORE;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall_c) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = '0;
            state_nxt   = DATA;
          end
        end
        IGNORE: begin
          sda_oe_nxt = 1'b0;
        end
        default: begin
          state_nxt  = IDLE;
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iic_target_rx.sv
// Directed bench for iic_target_rx: bench acts as I2C controller on an
// open-drain bus model and checks ACKs, received bytes and status outputs.
module tb_iic_target_rx;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addr_match;
  logic       busy;

  int n_pass = 0;
  int n_total = 0;

  int vcnt = 0;
  int oecnt = 0;
  int vdouble = 0;
  logic [7:0] vdata [$];
  logic       rx_valid_d = 1'b0;

  assign sda_line = (sda_oe || !m_sda) ? 1'b0 : 1'b1;

  always #5 clk = ~clk;

  iic_target_rx #(.OWN_ADDR(7'h42)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_line),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .addr_match(addr_match), .busy(busy)
  );

  // Strobe/ACK monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      vcnt = vcnt + 1;
      vdata.push_back(rx_data);
    end
    if (rx_valid && rx_valid_d) vdouble = vdouble + 1;
    if (sda_oe) oecnt = oecnt + 1;
    rx_valid_d = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; w(Q);
    scl = 1'b1;   w(Q);
    m_sda = 1'b0; w(Q);
    scl = 1'b0;   w(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; w(Q);
    scl = 1'b1;   w(Q);
    m_sda = 1'b1; w(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;  w(Q);
    scl = 1'b1; w(Q);
    scl = 1'b0; w(Q);
  endtask

  // Eight bits MSB first, then the 9th clock with SDA released; ack = line low.
  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; w(Q);
    scl = 1'b1;   w(Q/2);
    ack = !sda_line;
    w(Q/2);
    scl = 1'b0;   w(Q);
    chk("oe_released", 32'(sda_oe), 32'd0);
  endtask

  logic ack;
  int   v0, o0;

  initial begin
    // Reset state
    w(3);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_addr_match", 32'(addr_match), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    w(Q);
    chk("idle_busy", 32'(busy), 32'd0);

    // Write 0x42 with 0xAA
    v0 = vcnt;
    i2c_start();
    chk("t1_busy", 32'(busy), 32'd1);
    send_byte(8'h84, ack);
    chk("t1_addr_ack", 32'(ack), 32'd1);
    chk("t1_addr_match", 32'(addr_match), 32'd1);
    send_byte(8'hAA, ack);
    chk("t1_data_ack", 32'(ack), 32'd1);
    chk("t1_pulses", 32'(vcnt - v0), 32'd1);
    chk("t1_rx_data", 32'(rx_data), 32'hAA);
    chk("t1_match_held", 32'(addr_match), 32'd1);
    i2c_stop();
    chk("t1_busy_stop", 32'(busy), 32'd0);
    chk("t1_match_stop", 32'(addr_match), 32'd0);

    // Wrong address 0x43
    v0 = vcnt; o0 = oecnt;
    i2c_start();
    send_byte(8'h86, ack);
    chk("t2_nack", 32'(ack), 32'd0);
    chk("t2_match", 32'(addr_match), 32'd0);
    send_byte(8'h55, ack);
    chk("t2_data_nack", 32'(ack), 32'd0);
    chk("t2_oe_never", 32'(oecnt - o0), 32'd0);
    chk("t2_no_pulse", 32'(vcnt - v0), 32'd0);
    i2c_stop();
    chk("t2_busy_stop", 32'(busy), 32'd0);

    // Read request to 0x42
    o0 = oecnt;
    i2c_start();
    send_byte(8'h85, ack);
    chk("t3_nack", 32'(ack), 32'd0);
    chk("t3_busy_ignore", 32'(busy), 32'd1);
    i2c_stop();
    chk("t3_oe_never", 32'(oecnt - o0), 32'd0);
    chk("t3_busy_stop", 32'(busy), 32'd0);

    // Multi-byte write
    v0 = vcnt;
    vdata.delete();
    i2c_start();
    send_byte(8'h84, ack); chk("t4_addr_ack", 32'(ack), 32'd1);
    send_byte(8'h12, ack); chk("t4_ack0", 32'(ack), 32'd1);
    send_byte(8'h34, ack); chk("t4_ack1", 32'(ack), 32'd1);
    send_byte(8'hFF, ack); chk("t4_ack2", 32'(ack), 32'd1);
    chk("t4_pulses", 32'(vcnt - v0), 32'd3);
    if (vdata.size() == 3) begin
      chk("t4_byte0", 32'(vdata[0]), 32'h12);
      chk("t4_byte1", 32'(vdata[1]), 32'h34);
      chk("t4_byte2", 32'(vdata[2]), 32'hFF);
    end else begin
      chk("t4_queue_size", 32'(vdata.size()), 32'd3);
    end
    m_sda = 1'b0; w(Q);
    scl = 1'b1;   w(Q);
    m_sda = 1'b1; w(4);
    chk("t4_busy_stop", 32'(busy), 32'd0);
    chk("t4_match_stop", 32'(addr_match), 32'd0);
    w(Q);

    // Repeated START mid-byte
    v0 = vcnt;
    i2c_start();
    send_byte(8'h84, ack); chk("t5_addr_ack", 32'(ack), 32'd1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_start();
    chk("t5_match_cleared", 32'(addr_match), 32'd0);
    chk("t5_busy_kept", 32'(busy), 32'd1);
    chk("t5_no_partial", 32'(vcnt - v0), 32'd0);
    send_byte(8'h84, ack); chk("t5_addr_ack2", 32'(ack), 32'd1);
    send_byte(8'h5C, ack); chk("t5_data_ack", 32'(ack), 32'd1);
    chk("t5_pulses", 32'(vcnt - v0), 32'd1);
    chk("t5_rx_data", 32'(rx_data), 32'h5C);
    i2c_stop();

    // Reset during data ACK
    i2c_start();
    send_byte(8'h84, ack); chk("t6_addr_ack", 32'(ack), 32'd1);
    for (int i = 7; i >= 0; i--) send_bit(1'(i % 2));
    m_sda = 1'b1; w(2);
    chk("t6_oe_in_ack", 32'(sda_oe), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_oe_async", 32'(sda_oe), 32'd0);
    chk("t6_busy_async", 32'(busy), 32'd0);
    chk("t6_rx_data_async", 32'(rx_data), 32'h00);
    w(3);
    rst = 1'b1;
    w(Q);
    v0 = vcnt; o0 = oecnt;
    send_byte(8'h84, ack);
    chk("t6_nostart_nack", 32'(ack), 32'd0);
    send_byte(8'h77, ack);
    chk("t6_nostart_oe", 32'(oecnt - o0), 32'd0);
    chk("t6_nostart_pulse", 32'(vcnt - v0), 32'd0);
    chk("t6_nostart_busy", 32'(busy), 32'd0);
    scl = 1'b1; w(Q);
    i2c_start();
    send_byte(8'h84, ack); chk("t6_fresh_addr_ack", 32'(ack), 32'd1);
    send_byte(8'h3C, ack); chk("t6_fresh_data_ack", 32'(ack), 32'd1);
    chk("t6_fresh_pulse", 32'(vcnt - v0), 32'd1);
    chk("t6_fresh_data", 32'(rx_data), 32'h3C);
    i2c_stop();
    chk("t6_busy_stop", 32'(busy), 32'd0);

    chk("valid_width", 32'(vdouble), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
